// File: rtl/apb_pkg.sv
// Shared APB master definitions: controller states and transfer-type encodings.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic APB_RW_READ  = 1'b0;
   localparam logic APB_RW_WRITE = 1'b1;

endpackage : apb_pkg

// File: rtl/apb_decoder.sv
// Maps the top log2(NSLV) address bits to a slave index and its one-hot select.
module apb_decoder #(
   parameter int WADDR = 8,
   parameter int NSLV  = 4
) (
   input  logic [WADDR-1:0]         i_addr,
   output logic [NSLV-1:0]          o_sel,
   output logic [$clog2(NSLV)-1:0]  o_idx
);

   localparam int SW = $clog2(NSLV);

   always_comb begin
      o_idx        = i_addr[WADDR-1 -: SW];
      o_sel        = '0;
      o_sel[o_idx] = 1'b1;
   end

endmodule : apb_decoder

// File: rtl/apb_master_nslv.sv
// Single-command APB master driving NSLV address-decoded slaves, with a
// bounded wait-state timeout that completes the transfer with an error.
module apb_master_nslv #(
   parameter int WADDR   = 8,
   parameter int WDATA   = 8,
   parameter int NSLV    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                    i_PCLK,
   input  logic                    i_PRESET,
   input  logic                    i_TRANSACTION,
   output logic                    o_READY,
   input  logic                    i_RW,
   input  logic [WADDR-1:0]        i_SLV_ADDR,
   input  logic [WDATA-1:0]        i_SLV_WDATA,
   output logic                    o_DONE,
   output logic                    o_ERR,
   output logic [WDATA-1:0]        o_PRDATA,
   output logic [NSLV-1:0]         o_PSEL,
   output logic                    o_PENABLE,
   output logic                    o_PWRITE,
   output logic [WADDR-1:0]        o_PADDR,
   output logic [WDATA-1:0]        o_PWDATA,
   input  logic [NSLV*WDATA-1:0]   i_PRDATA,
   input  logic [NSLV-1:0]         i_PREADY,
   input  logic [NSLV-1:0]         i_PSLVERR
);

   import apb_pkg::*;

   localparam int SW = $clog2(NSLV);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   apb_state_e        state_q;
   logic [CW-1:0]     cnt_q;
   logic [SW-1:0]     sel_idx_q;
   logic [NSLV-1:0]   psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [WADDR-1:0]  paddr_q;
   logic [WDATA-1:0]  pwdata_q;
   logic [WDATA-1:0]  prdata_q;
   logic              done_q;
   logic              err_q;

   logic [NSLV-1:0]   dec_sel;
   logic [SW-1:0]     dec_idx;
   logic              sel_ready;
   logic              sel_err;
   logic [WDATA-1:0]  sel_rdata;
   logic              timeout_hit;

   apb_decoder #(
      .WADDR (WADDR),
      .NSLV  (NSLV)
   ) u_decoder (
      .i_addr (i_SLV_ADDR),
      .o_sel  (dec_sel),
      .o_idx  (dec_idx)
   );

   // Only the selected slave's response is observed; the others may drive anything.
   assign sel_ready   = i_PREADY[sel_idx_q];
   assign sel_err     = i_PSLVERR[sel_idx_q];
   assign sel_rdata   = i_PRDATA[int'(sel_idx_q)*WDATA +: WDATA];
   assign timeout_hit = !sel_ready && (cnt_q == CNT_LAST);

   // NOTE: every register here, data included, is reset so that an aborted
   // transfer leaves the bus and status outputs at a known zero.
   always_ff @(posedge i_PCLK or posedge i_PRESET) begin
      if (i_PRESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sel_idx_q <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         prdata_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, independent of statement order.
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_TRANSACTION) begin
                  state_q   <= SETUP;
                  pwrite_q  <= i_RW;
                  paddr_q   <= i_SLV_ADDR;
                  pwdata_q  <= i_SLV_WDATA;
                  psel_q    <= dec_sel;
                  sel_idx_q <= dec_idx;
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
               cnt_q     <= '0;
            end
            ACCESS: begin
               if (sel_ready || timeout_hit) begin
                  state_q   <= IDLE;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  done_q    <= 1'b1;
                  // A ready response wins over a coincident timeout.
                  err_q     <= sel_ready ? sel_err : 1'b1;
                  if (sel_ready && !sel_err && (pwrite_q == APB_RW_READ)) begin
                     prdata_q <= sel_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_READY   = (state_q == IDLE);
   assign o_DONE    = done_q;
   assign o_ERR     = err_q;
   assign o_PRDATA  = prdata_q;
   assign o_PSEL    = psel_q;
   assign o_PENABLE = penable_q;
   assign o_PWRITE  = pwrite_q;
   assign o_PADDR   = paddr_q;
   assign o_PWDATA  = pwdata_q;

endmodule : apb_master_nslv

// File: tb/tb_apb_master_nslv.sv
// Randomised bench for apb_master_nslv against a transfer-level model with
// memory-backed slaves that drive noise whenever they are not addressed.
module tb_apb_master_nslv;

   import apb_pkg::*;

   localparam int WADDR   = 8;
   localparam int WDATA   = 8;
   localparam int NSLV    = 4;
   localparam int TIMEOUT = 16;

   logic                   clk = 1'b0;
   logic                   i_PRESET;
   logic                   i_TRANSACTION;
   logic                   o_READY;
   logic                   i_RW;
   logic [WADDR-1:0]       i_SLV_ADDR;
   logic [WDATA-1:0]       i_SLV_WDATA;
   logic                   o_DONE;
   logic                   o_ERR;
   logic [WDATA-1:0]       o_PRDATA;
   logic [NSLV-1:0]        o_PSEL;
   logic                   o_PENABLE;
   logic                   o_PWRITE;
   logic [WADDR-1:0]       o_PADDR;
   logic [WDATA-1:0]       o_PWDATA;
   logic [NSLV*WDATA-1:0]  i_PRDATA;
   logic [NSLV-1:0]        i_PREADY;
   logic [NSLV-1:0]        i_PSLVERR;

   int n_vec = 0;
   int n_err = 0;

   logic [WDATA-1:0] mem [2**WADDR];
   logic             exp_err;
   logic [WDATA-1:0] exp_prdata;

   always #5 clk = ~clk;

   apb_master_nslv #(
      .WADDR   (WADDR),
      .WDATA   (WDATA),
      .NSLV    (NSLV),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_PCLK        (clk),
      .i_PRESET      (i_PRESET),
      .i_TRANSACTION (i_TRANSACTION),
      .o_READY       (o_READY),
      .i_RW          (i_RW),
      .i_SLV_ADDR    (i_SLV_ADDR),
      .i_SLV_WDATA   (i_SLV_WDATA),
      .o_DONE        (o_DONE),
      .o_ERR         (o_ERR),
      .o_PRDATA      (o_PRDATA),
      .o_PSEL        (o_PSEL),
      .o_PENABLE     (o_PENABLE),
      .o_PWRITE      (o_PWRITE),
      .o_PADDR       (o_PADDR),
      .o_PWDATA      (o_PWDATA),
      .i_PRDATA      (i_PRDATA),
      .i_PREADY      (i_PREADY),
      .i_PSLVERR     (i_PSLVERR)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // The address space is split evenly between the slaves.
   function automatic int slave_of(input logic [WADDR-1:0] a);
      return int'(a) / ((2**WADDR) / NSLV);
   endfunction

   task automatic drive_slaves(input int tgt, input logic rdy, input logic err,
                               input logic [WDATA-1:0] data);
      for (int k = 0; k < NSLV; k++) begin
         if (k == tgt) begin
            i_PREADY[k]                 = rdy;
            i_PSLVERR[k]                = err;
            i_PRDATA[k*WDATA +: WDATA]  = data;
         end else begin
            i_PREADY[k]                 = 1'b1;
            i_PSLVERR[k]                = 1'b1;
            i_PRDATA[k*WDATA +: WDATA]  = WDATA'($urandom);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},   o_READY,   1);
      check({tag, "_psel"},    o_PSEL,    0);
      check({tag, "_penable"}, o_PENABLE, 0);
      check({tag, "_pwrite"},  o_PWRITE,  0);
      check({tag, "_paddr"},   o_PADDR,   0);
      check({tag, "_pwdata"},  o_PWDATA,  0);
      check({tag, "_done"},    o_DONE,    0);
      check({tag, "_err"},     o_ERR,     0);
      check({tag, "_prdata"},  o_PRDATA,  0);
   endtask

   // Called at a negedge with the DUT idle. waits < 0 means the slave never
   // answers. Cycle n counts from the accept cycle (n = 0); o_DONE is due in
   // cycle 3 + number of wait states. abort_at >= 1 resets in that cycle.
   task automatic xfer(input logic rw, input logic [WADDR-1:0] addr,
                       input logic [WDATA-1:0] wdata, input int waits,
                       input logic slverr, input logic hold, input int abort_at);
      int               tgt;
      int               n_done;
      logic             timed_out;
      logic [NSLV-1:0]  onehot;
      tgt       = slave_of(addr);
      onehot    = '0;
      onehot[tgt] = 1'b1;
      timed_out = (waits < 0) || (waits >= TIMEOUT);
      n_done    = 3 + (timed_out ? TIMEOUT - 1 : waits);

      check("ready_idle", o_READY, 1);
      i_TRANSACTION = 1'b1;
      i_RW          = rw;
      i_SLV_ADDR    = addr;
      i_SLV_WDATA   = wdata;
      drive_slaves(tgt, 1'b0, slverr, mem[addr]);

      for (int n = 1; n <= n_done; n++) begin
         @(negedge clk);
         if (!hold) i_TRANSACTION = 1'b0;
         if (n == abort_at) begin
            #2 i_PRESET = 1'b1;
            #1;
            exp_err    = 1'b0;
            exp_prdata = '0;
            check_reset_outputs("abort");
            @(negedge clk);
            check("abort_hold_done", o_DONE, 0);
            i_PRESET = 1'b0;
            @(negedge clk);
            check("abort_rel_ready", o_READY, 1);
            check("abort_rel_done",  o_DONE,  0);
            check("abort_rel_psel",  o_PSEL,  0);
            return;
         end
         if (n < n_done) begin
            check("psel",    o_PSEL,    onehot);
            check("penable", o_PENABLE, (n >= 2));
            check("paddr",   o_PADDR,   addr);
            check("pwrite",  o_PWRITE,  rw);
            check("pwdata",  o_PWDATA,  wdata);
            check("busy",    o_READY,   0);
            check("early",   o_DONE,    0);
            drive_slaves(tgt, (n >= 2) && !timed_out && (n - 2 >= waits), slverr, mem[addr]);
         end else begin
            exp_err = timed_out ? 1'b1 : slverr;
            if (!timed_out && !slverr) begin
               if (rw == APB_RW_WRITE) mem[addr] = wdata;
               else                    exp_prdata = mem[addr];
            end
            check("done",       o_DONE,    1);
            check("err",        o_ERR,     exp_err);
            check("prdata",     o_PRDATA,  exp_prdata);
            check("psel_off",   o_PSEL,    0);
            check("penable_off", o_PENABLE, 0);
         end
      end
   endtask

   initial begin
      int r;
      int waits;
      logic hold;

      for (int a = 0; a < 2**WADDR; a++) mem[a] = WDATA'($urandom);
      exp_err       = 1'b0;
      exp_prdata    = '0;
      i_TRANSACTION = 1'b0;
      i_RW          = 1'b0;
      i_SLV_ADDR    = '0;
      i_SLV_WDATA   = '0;
      i_PRDATA      = '0;
      i_PREADY      = '0;
      i_PSLVERR     = '0;
      i_PRESET      = 1'b1;
      #3;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      i_PRESET = 1'b0;
      @(negedge clk);

      // Directed: zero-wait write, waited read, slave error, timeout edges.
      xfer(APB_RW_WRITE, 8'hAA, 8'h18, 0, 1'b0, 1'b0, -1);
      xfer(APB_RW_READ,  8'hAA, 8'h00, 2, 1'b0, 1'b0, -1);
      xfer(APB_RW_READ,  8'h18, 8'h00, 0, 1'b1, 1'b0, -1);
      xfer(APB_RW_READ,  8'h40, 8'h00, -1, 1'b0, 1'b0, -1);
      xfer(APB_RW_READ,  8'h41, 8'h00, TIMEOUT - 1, 1'b0, 1'b0, -1);
      xfer(APB_RW_WRITE, 8'hC3, 8'h5A, TIMEOUT - 1, 1'b1, 1'b0, -1);

      // Back-to-back with i_TRANSACTION held, noisy unselected slaves.
      xfer(APB_RW_WRITE, 8'hBB, 8'h67, 0, 1'b0, 1'b1, -1);
      xfer(APB_RW_READ,  8'hBB, 8'h00, 0, 1'b0, 1'b0, -1);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            6:       waits = TIMEOUT - 1;
            7:       waits = TIMEOUT;
            8:       waits = -1;
            9:       waits = 1;
            default: waits = r % 4;
         endcase
         hold = (i < 39) && ($urandom_range(0, 1) == 1);
         xfer(1'($urandom), WADDR'($urandom), WDATA'($urandom), waits,
              ($urandom_range(0, 3) == 0), hold, -1);
         if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset during a wait state of a read.
      xfer(APB_RW_READ, 8'h55, 8'h00, -1, 1'b0, 1'b0, 5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_apb_master_nslv

// File: doc/apb_master_nslv.md
APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter WADDR, default 8: address width in bits.
REQ-002 SHALL have parameter WDATA, default 8: data width in bits.
REQ-003 SHALL have parameter NSLV, default 4: number of slaves; a power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before the transfer is aborted; at least 1.
REQ-005 SHALL have one clock and an asynchronous active-high reset.
REQ-006 Ports (name, direction, width, meaning):
- i_PCLK  in  1  clock.
- i_PRESET  in  1  async active-high reset.
- i_TRANSACTION  in  1  command valid.
- o_READY  out  1  command accepted when high together with i_TRANSACTION.
- i_RW  in  1  transfer type: 1 = write, 0 = read.
- i_SLV_ADDR  in  WADDR  command address.
- i_SLV_WDATA  in  WDATA  write data.
- o_DONE  out  1  one-cycle completion pulse.
- o_ERR  out  1  error status of the last completed transfer.
- o_PRDATA  out  WDATA  data from the last completed read.
- o_PSEL  out  NSLV  one-hot slave select.
- o_PENABLE  out  1  APB enable.
- o_PWRITE  out  1  APB write.
- o_PADDR  out  WADDR  APB address.
- o_PWDATA  out  WDATA  APB write data.
- i_PRDATA  in  NSLV*WDATA  slave read data; slave k occupies bits [k*WDATA +: WDATA].
- i_PREADY  in  NSLV  per-slave ready.
- i_PSLVERR  in  NSLV  per-slave error.

Function
REQ-007 SHALL implement the state machine IDLE -> SETUP -> ACCESS -> IDLE.
REQ-008 o_READY SHALL be 1 only in IDLE; the accept edge registers i_RW, i_SLV_ADDR and i_SLV_WDATA and moves the state to SETUP.
REQ-009 The selected slave index SHALL be the top log2(NSLV) bits of the registered address; o_PSEL SHALL be one-hot on that index in SETUP and ACCESS and all-zero otherwise.
REQ-010 o_PENABLE SHALL be 0 in SETUP and 1 in ACCESS.
REQ-011 o_PADDR, o_PWRITE and o_PWDATA SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-012 SETUP SHALL always go to ACCESS after exactly one cycle.
REQ-013 ACCESS SHALL complete on the first cycle in which i_PREADY of the selected slave is 1; i_PREADY, i_PSLVERR and i_PRDATA of unselected slaves SHALL be ignored.
REQ-014 A wait-cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with the selected i_PREADY low.
REQ-015 When the counter reaches TIMEOUT, the transfer SHALL complete with an error.
REQ-016 The counter SHALL be wide enough to reach TIMEOUT without wrapping.
REQ-017 On completion, the next state SHALL be IDLE, and the following cycle SHALL show o_DONE=1 for one cycle.
REQ-018 At that completion, o_ERR SHALL load (selected i_PSLVERR OR timeout) and hold until the next completion.
REQ-019 On completion of a read that is neither timed out nor errored, o_PRDATA SHALL load the selected slave's data; on writes or errors, o_PRDATA SHALL hold its previous value.
REQ-020 Minimum latency SHALL be: accept edge -> o_DONE visible 3 cycles later with zero wait states, plus 1 cycle per wait state.
REQ-021 If i_PREADY and the timeout occur in the same cycle, the transfer SHALL be treated as a normal PREADY completion and o_ERR SHALL equal the selected i_PSLVERR.
REQ-022 i_TRANSACTION held high SHALL produce back-to-back transfers, each re-accepted in IDLE, giving one idle cycle between transfers.

Reset
REQ-023 While i_PRESET=1, outputs SHALL be: state IDLE, o_READY=1, and all other outputs 0 (o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA, o_DONE, o_ERR, o_PRDATA); the counter SHALL be cleared.
REQ-024 A reset asserted mid-transfer SHALL abort it immediately, produce no o_DONE, and leave o_ERR and o_PRDATA at 0.

Structure
REQ-025 The shared package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the APB_RW_READ and APB_RW_WRITE constants.
REQ-026 The address-to-one-hot decode SHALL be a sub-module apb_decoder, parametrised by WADDR and NSLV.

Verification
REQ-027 Write, zero-wait: write to 0xAA with data 0x18, slave 2 PREADY tied 1 -> o_PSEL=0100, o_PENABLE low for 1 cycle then high for 1 cycle; o_DONE 3 cycles after accept; o_ERR=0.
REQ-028 Read with wait states: read 0xAA, slave 2 returns 0x18 after 2 wait cycles -> o_DONE 5 cycles after accept; o_PRDATA=0x18; o_PADDR stable throughout.
REQ-029 Error: read 0x18 (slave 0) with i_PSLVERR[0]=1 at PREADY -> o_ERR=1; o_PRDATA unchanged.
REQ-030 Timeout: TIMEOUT=16, selected PREADY held 0 -> completion after 16 ACCESS cycles with o_ERR=1; o_PSEL returns to 0.
REQ-031 Decode isolation and back-to-back: i_TRANSACTION held high; write 0xBB=0x67, then read 0xBB; unselected slaves drive PREADY=1 and PSLVERR=1 -> only o_PSEL[2] asserts; read returns 0x67; o_ERR=0; one IDLE cycle between transfers.
REQ-032 Reset mid-ACCESS: assert i_PRESET during a wait state -> all outputs reach reset values without a clock edge; no o_DONE; o_READY=1 after release.
